uart_send_cfg: RTL and testbench

//  Parametrised UART transmitter: configurable data width, parity mode and stop-bit count.

---
 rtl/uart_send_cfg.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_send_cfg.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_send_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_send_cfg
// Purpose  : Parametrised UART transmitter with a valid/ready input handshake.
//            Data width (5..9), parity (none/odd/even) and stop-bit count
//            (1..2) are configurable. Bits go out LSB first. Each bit lasts
//            CLK_FREQ/UART_BPS clocks. Every output comes from a flop.
// Ports    : sys_clk  - system clock, rising edge
//            sys_rst  - synchronous reset, active-high
//            tx_valid - producer has a word on tx_data
//            tx_ready - a word can be accepted this cycle
//            tx_data  - word to send, sampled on tx_valid && tx_ready
//            uart_txd - serial line, idle high
//            tx_busy  - frame in progress
//            tx_done  - one-cycle pulse when a frame completes
//            rs485_de - RS485 driver enable (UART_SEND_RS485_DE_EN only)
// Options  : macro UART_SEND_RS485_DE_EN adds rs485_de. It also adds a
//            DE_HOLD-clock HOLD state after the last stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_send_cfg #(
    parameter int CLK_FREQ  = 50000000,
    parameter int UART_BPS  = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int CNT_W     = 16,
    parameter int DE_HOLD   = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 uart_txd,
    output logic                 tx_busy,
`ifdef UART_SEND_RS485_DE_EN
    output logic                 rs485_de,
`endif
    output logic                 tx_done
);

    localparam int c_BPS_CNT = CLK_FREQ / UART_BPS;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(c_BPS_CNT - 1);
    localparam logic [CNT_W-1:0] c_CNT_PEN  = CNT_W'(c_BPS_CNT - 2);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       c_STOP_LAST = 4'(STOP_BITS - 1);
    localparam bit               c_PAR_EN    = (PARITY != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_SEND_RS485_DE_EN
    localparam logic [2:0] S_HOLD   = 3'd5;
    localparam int         c_HOLD_W = (DE_HOLD > 1) ? $clog2(DE_HOLD + 1) : 1;
`endif

    generate
        if ((DATA_BITS < 5) || (DATA_BITS > 9) || (PARITY < 0) || (PARITY > 2) ||
            (STOP_BITS < 1) || (STOP_BITS > 2) || (c_BPS_CNT < 2) || (DE_HOLD < 0) ||
            (((c_BPS_CNT - 1) >> CNT_W) != 0)) begin : g_param_error
            $error("uart_send_cfg: illegal parameter combination");
        end
    endgenerate

    logic [2:0]           r_state,   w_state_nxt;
    logic [CNT_W-1:0]     r_clk_cnt, w_clk_cnt_nxt;
    logic [3:0]           r_bit_idx, w_bit_idx_nxt;
    logic [DATA_BITS-1:0] r_shift,   w_shift_nxt;
    logic                 r_par,     w_par_nxt;
    logic                 r_txd,     w_txd_nxt;
    logic                 r_busy,    w_busy_nxt;
    logic                 r_ready,   w_ready_nxt;
    logic                 r_done,    w_done_nxt;
    logic                 w_wrap;
`ifdef UART_SEND_RS485_DE_EN
    logic                 r_de,      w_de_nxt;
    logic [c_HOLD_W-1:0]  r_hold_cnt, w_hold_cnt_nxt;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_par_nxt     = r_par;
        w_txd_nxt     = r_txd;
        w_busy_nxt    = r_busy;
        w_ready_nxt   = r_ready;
        w_done_nxt    = 1'b0;
`ifdef UART_SEND_RS485_DE_EN
        w_de_nxt       = r_de;
        w_hold_cnt_nxt = r_hold_cnt;
`endif
        w_wrap = (r_clk_cnt == c_CNT_LAST);

        case (r_state)
            S_IDLE: begin
                if (tx_valid && r_ready) begin
                    w_state_nxt   = S_START;
                    w_clk_cnt_nxt = '0;
                    w_shift_nxt   = tx_data;
                    // Parity is fixed at accept time from the latched word.
                    w_par_nxt     = (PARITY == 1) ? ~^tx_data : ^tx_data;
                    w_txd_nxt     = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_ready_nxt   = 1'b0;
`ifdef UART_SEND_RS485_DE_EN
                    w_de_nxt      = 1'b1;
`endif
                end
            end
            S_START: begin
                if (w_wrap) begin
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = S_DATA;
                    w_bit_idx_nxt = '0;
                    w_txd_nxt     = r_shift[0];
                    w_shift_nxt   = r_shift >> 1;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CNT_ONE;
                end
            end
            S_DATA: begin
                if (w_wrap) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit_idx == c_DATA_LAST) begin
                        w_bit_idx_nxt = '0;
                        if (c_PAR_EN) begin
                            w_state_nxt = S_PARITY;
                            w_txd_nxt   = r_par;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_txd_nxt   = 1'b1;
                        end
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 4'd1;
                        w_txd_nxt     = r_shift[0];
                        w_shift_nxt   = r_shift >> 1;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CNT_ONE;
                end
            end
            S_PARITY: begin
                if (w_wrap) begin
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = S_STOP;
                    w_bit_idx_nxt = '0;
                    w_txd_nxt     = 1'b1;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CNT_ONE;
                end
            end
            S_STOP: begin
                // The frame closes one clock early. The cycle carrying
                // tx_done/tx_ready is the final clock of the last stop bit.
                // A word offered then starts its start bit with no idle gap.
                if ((r_bit_idx == c_STOP_LAST) && (r_clk_cnt == c_CNT_PEN)) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_idx_nxt = '0;
                    w_busy_nxt    = 1'b0;
                    w_done_nxt    = 1'b1;
`ifdef UART_SEND_RS485_DE_EN
                    if (DE_HOLD > 0) begin
                        w_state_nxt    = S_HOLD;
                        w_hold_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_ready_nxt = 1'b1;
                        w_de_nxt    = 1'b0;
                    end
`else
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = 1'b1;
`endif
                end else if (w_wrap) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_idx_nxt = r_bit_idx + 4'd1;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CNT_ONE;
                end
            end
`ifdef UART_SEND_RS485_DE_EN
            S_HOLD: begin
                // The first HOLD cycle is the tail of the stop bit. DE_HOLD
                // more clocks follow, then the driver is released.
                if (r_hold_cnt == c_HOLD_W'(DE_HOLD)) begin
                    w_state_nxt    = S_IDLE;
                    w_hold_cnt_nxt = '0;
                    w_ready_nxt    = 1'b1;
                    w_de_nxt       = 1'b0;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + c_HOLD_W'(1);
                end
            end
`endif
            default: begin
                w_state_nxt   = S_IDLE;
                w_clk_cnt_nxt = '0;
                w_bit_idx_nxt = '0;
                w_txd_nxt     = 1'b1;
                w_busy_nxt    = 1'b0;
                w_ready_nxt   = 1'b1;
`ifdef UART_SEND_RS485_DE_EN
                w_de_nxt      = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
`ifdef UART_SEND_RS485_DE_EN
            r_de       <= 1'b0;
            r_hold_cnt <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_par     <= w_par_nxt;
            r_txd     <= w_txd_nxt;
            r_busy    <= w_busy_nxt;
            r_ready   <= w_ready_nxt;
            r_done    <= w_done_nxt;
`ifdef UART_SEND_RS485_DE_EN
            r_de       <= w_de_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
`endif
        end
    end

    assign uart_txd = r_txd;
    assign tx_busy  = r_busy;
    assign tx_ready = r_ready;
    assign tx_done  = r_done;
`ifdef UART_SEND_RS485_DE_EN
    assign rs485_de = r_de;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_send_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_send_cfg
// Purpose  : Self-checking bench for uart_send_cfg. It has five instances:
//            8N1, 8E1, 8O1, 7O2 and 8N1 with DE_HOLD=16. The bench model
//            describes each frame as a bit list indexed by time since accept.
//            Directed frames pin the model with hand-computed literals.
// Options  : build with UART_SEND_RS485_DE_EN to check rs485_de and HOLD.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_send_cfg;

    localparam int N   = 5;
    localparam int BPS = 10;
`ifdef UART_SEND_RS485_DE_EN
    localparam bit c_DE_ON = 1'b1;
`else
    localparam bit c_DE_ON = 1'b0;
`endif

    function automatic int cfg_db(input int k);
        return (k == 3) ? 7 : 8;
    endfunction
    function automatic int cfg_pb(input int k);
        case (k)
            1:       return 2;
            2, 3:    return 1;
            default: return 0;
        endcase
    endfunction
    function automatic int cfg_sb(input int k);
        return (k == 3) ? 2 : 1;
    endfunction
    function automatic int cfg_hold(input int k);
        return (k == 4) ? 16 : 0;
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid [N];
    logic [8:0] data  [N];
    logic       txd   [N];
    logic       busy  [N];
    logic       done  [N];
    logic       ready [N];
    logic       de    [N];

    always #5 clk = ~clk;

    generate
        for (genvar k = 0; k < N; k++) begin : g_dut
            uart_send_cfg #(
                .CLK_FREQ (1000000),
                .UART_BPS (100000),
                .DATA_BITS(cfg_db(k)),
                .PARITY   (cfg_pb(k)),
                .STOP_BITS(cfg_sb(k)),
                .CNT_W    (16),
                .DE_HOLD  (cfg_hold(k))
            ) u_dut (
                .sys_clk (clk),
                .sys_rst (rst),
                .tx_valid(valid[k]),
                .tx_ready(ready[k]),
                .tx_data (data[k][cfg_db(k)-1:0]),
                .uart_txd(txd[k]),
                .tx_busy (busy[k]),
`ifdef UART_SEND_RS485_DE_EN
                .rs485_de(de[k]),
`endif
                .tx_done (done[k])
            );
`ifndef UART_SEND_RS485_DE_EN
            assign de[k] = 1'b0;
`endif
        end
    endgenerate

    // ---------------- behavioural model ----------------
    int         n_checks = 0;
    int         n_pass   = 0;
    bit         chk_en   = 1'b0;
    bit         act  [N];
    int         t    [N];
    logic [8:0] mdat [N];

    function automatic int frame_len(input int k);
        return (1 + cfg_db(k) + ((cfg_pb(k) != 0) ? 1 : 0) + cfg_sb(k)) * BPS;
    endfunction

    // Cycle index (from accept) at which tx_ready is high again.
    function automatic int ready_t(input int k);
        int h;
        h = c_DE_ON ? cfg_hold(k) : 0;
        return (h > 0) ? frame_len(k) + h : frame_len(k) - 1;
    endfunction

    // Bit number b of the frame: start, data LSB first, parity, stop bits.
    function automatic logic line_bit(input int k, input logic [8:0] d, input int b);
        logic [8:0] m;
        m = d & 9'((1 << cfg_db(k)) - 1);
        if (b == 0) return 1'b0;
        if (b <= cfg_db(k)) return m[b-1];
        if ((cfg_pb(k) != 0) && (b == cfg_db(k) + 1)) return (cfg_pb(k) == 1) ? ~^m : ^m;
        return 1'b1;
    endfunction

    // {txd, busy, done, ready, de}
    function automatic logic [4:0] expect_vec(input int k);
        int   tt, fl, r;
        logic e_txd;
        if (!act[k]) return 5'b10010;
        tt = t[k];
        fl = frame_len(k);
        r  = ready_t(k);
        e_txd = (tt < fl) ? line_bit(k, mdat[k], tt / BPS) : 1'b1;
        return {e_txd, (tt < fl - 1), (tt == fl - 1), (tt >= r), (c_DE_ON && (tt < r))};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                act[k] <= 1'b0;
                t[k]   <= 0;
            end else if (valid[k] && (!act[k] || t[k] >= ready_t(k))) begin
                act[k]  <= 1'b1;
                t[k]    <= 0;
                mdat[k] <= data[k];
            end else if (act[k]) begin
                if (t[k] >= ready_t(k)) act[k] <= 1'b0;
                else                    t[k]   <= t[k] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < N; k++) begin
                check($sformatf("cycle u%0d t=%0d", k, t[k]),
                      {27'd0, txd[k], busy[k], done[k], ready[k], de[k]},
                      {27'd0, expect_vec(k)});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input int k);
        int n;
        n = 0;
        while (ready[k] !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) check($sformatf("ready timeout u%0d", k), {31'd0, ready[k]}, 32'd1);
    endtask

    task automatic send(input int k, input logic [8:0] d);
        wait_ready(k);
        valid[k] = 1'b1;
        data[k]  = d;
        tick();
        valid[k] = 1'b0;
    endtask

    // Sends d, samples every bit mid-period, reports the cycle (1 = first
    // cycle after accept) where tx_done is seen and tx_ready at that cycle.
    task automatic run_frame(input int k, input logic [8:0] d, input int nbits,
                             output logic [15:0] cap, output int done_n, output logic rdy);
        int n;
        send(k, d);
        cap = '0; done_n = 0; rdy = 1'b0;
        n = 1;
        while (n < 400) begin
            if (((n - 1) % BPS == 5) && ((n - 1) / BPS < nbits)) cap[(n - 1) / BPS] = txd[k];
            if (done[k] === 1'b1) begin
                done_n = n;
                rdy    = ready[k];
                break;
            end
            tick();
            n++;
        end
    endtask

    initial begin
        logic [15:0] cap;
        int          dn, n, n1, n2, cnt, de_cnt, first_rdy;
        logic        rdy, txd_end, txd_next;
        for (int k = 0; k < N; k++) begin
            valid[k] = 1'b0;
            data[k]  = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick();
        check("reset state u0", {28'd0, txd[0], busy[0], done[0], ready[0]}, 32'b1001);
        check("reset de u4", {31'd0, de[4]}, 32'd0);
        rst = 1'b0;
        repeat (5) tick();
        check("idle txd high", {31'd0, txd[0]}, 32'd1);

        // 8N1 0x55
        run_frame(0, 9'h055, 10, cap, dn, rdy);
        check("8N1 0x55 bits", {22'd0, cap[9:0]}, 32'h2AA);
        check("8N1 done cycle", dn, 100);
        check("8N1 ready with done", {31'd0, rdy}, 32'd1);

        // 8E1 / 8O1 0x07, 7O2 0x7F
        run_frame(1, 9'h007, 11, cap, dn, rdy);
        check("8E1 0x07 bits", {21'd0, cap[10:0]}, 32'h60E);
        check("8E1 done cycle", dn, 110);
        run_frame(2, 9'h007, 11, cap, dn, rdy);
        check("8O1 0x07 bits", {21'd0, cap[10:0]}, 32'h40E);
        run_frame(3, 9'h07F, 11, cap, dn, rdy);
        check("7O2 0x7F bits", {21'd0, cap[10:0]}, 32'h6FE);
        check("7O2 done cycle", dn, 110);

        // Back-to-back 0xA3 then 0x3C with tx_valid held high.
        wait_ready(0);
        valid[0] = 1'b1;
        data[0]  = 9'h0A3;
        tick();
        data[0]  = 9'h03C;
        n = 1; n1 = 0; n2 = 0; txd_end = 1'bx; txd_next = 1'bx;
        while (n < 400) begin
            if (n1 != 0 && n == n1 + 1) begin
                txd_next = txd[0];
                valid[0] = 1'b0;
            end
            if (done[0] === 1'b1) begin
                if (n1 == 0) begin
                    n1 = n;
                    txd_end = txd[0];
                end else begin
                    n2 = n;
                    break;
                end
            end
            tick();
            n++;
        end
        valid[0] = 1'b0;
        check("b2b first done", n1, 100);
        check("b2b done spacing", n2 - n1, 100);
        check("b2b last stop clock", {31'd0, txd_end}, 32'd1);
        check("b2b start no gap", {31'd0, txd_next}, 32'd0);

        // Reset at clock 35 of a frame.
        send(0, 9'h05A);
        for (int i = 1; i < 35; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid-frame reset", {28'd0, txd[0], busy[0], ready[0], done[0]}, 32'b1010);
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            if (done[0] === 1'b1) cnt++;
            tick();
        end
        check("no done after reset", cnt, 0);
        run_frame(0, 9'h0C3, 10, cap, dn, rdy);
        check("post-reset 0xC3 bits", {22'd0, cap[9:0]}, 32'h386);
        check("post-reset done cycle", dn, 100);

        // RS485 driver-enable window (8N1, DE_HOLD=16 instance), 0x00.
        send(4, 9'h000);
        n = 1; dn = 0; de_cnt = 0; first_rdy = 0;
        while (n < 300 && first_rdy == 0) begin
            if (de[4] === 1'b1) de_cnt++;
            if (done[4] === 1'b1 && dn == 0) dn = n;
            if (ready[4] === 1'b1) first_rdy = n;
            tick();
            n++;
        end
        check("de inst done cycle", dn, 100);
`ifdef UART_SEND_RS485_DE_EN
        check("rs485_de high clocks", de_cnt, 116);
        check("ready after hold", first_rdy, 117);
`else
        check("de inst ready with done", first_rdy, 100);
`endif
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
